// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of projectile slots for a tank game.
//
// Fires allocate the lowest free slot. A cooldown counter limits the fire rate.
// A movement divider moves every live bullet SPEED pixels per tick.
// A bullet is retired when it would leave the screen or when it overlaps an
// alive target; the lowest-index overlapped target gets the hit.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   fire, fire_dir          fire request and direction (00 up, 01 down, 10 left, 11 right)
//   init_x, init_y          spawn position (bullet top-left)
//   target_x/_y/_alive      flattened target positions (10 bits each) and enables
//   fire_accept, fire_drop  one-cycle pulses for accepted or refused fires
//   hit                     one-cycle pulse per struck target
//   active, active_count    slot occupancy and number of occupied slots
//   bullet_x/_y/_dir        flattened slot state; valid only where active is set
module bullet_pool #(
    parameter int MAX_BULLETS = 8,
    parameter int NUM_TARGETS = 2,
    parameter int SPEED       = 4,
    parameter int MOVE_DIV    = 1,
    parameter int COOLDOWN    = 16,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BULLET_SIZE = 4,
    parameter int TANK_SIZE   = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               fire,
    input  logic [1:0]                         fire_dir,
    input  logic [9:0]                         init_x,
    input  logic [9:0]                         init_y,
    input  logic [10*NUM_TARGETS-1:0]          target_x,
    input  logic [10*NUM_TARGETS-1:0]          target_y,
    input  logic [NUM_TARGETS-1:0]             target_alive,
    output logic                               fire_accept,
    output logic                               fire_drop,
    output logic [NUM_TARGETS-1:0]             hit,
    output logic [MAX_BULLETS-1:0]             active,
    output logic [10*MAX_BULLETS-1:0]          bullet_x,
    output logic [10*MAX_BULLETS-1:0]          bullet_y,
    output logic [2*MAX_BULLETS-1:0]           bullet_dir,
    output logic [$clog2(MAX_BULLETS+1)-1:0]   active_count
);

    localparam int SW = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int NW = $clog2(MAX_BULLETS + 1);

    localparam logic [10:0] X_MAX = 11'(SCREEN_W - BULLET_SIZE);
    localparam logic [10:0] Y_MAX = 11'(SCREEN_H - BULLET_SIZE);
    localparam logic [10:0] SPD   = 11'(SPEED);
    localparam logic [10:0] B_SZ  = 11'(BULLET_SIZE);
    localparam logic [10:0] T_SZ  = 11'(TANK_SIZE);

    // One movement step in 11-bit space; returns {in_bounds, new_x, new_y}.
    // An underflow is caught before subtracting, so no value can wrap.
    function automatic logic [20:0] move_step(input logic [9:0] x, input logic [9:0] y,
                                              input logic [1:0] d);
        logic [10:0] nx;
        logic [10:0] ny;
        logic        ok;
        nx = {1'b0, x};
        ny = {1'b0, y};
        ok = 1'b1;
        case (d)
            2'b00:   if (ny < SPD) ok = 1'b0; else ny = ny - SPD;
            2'b01:   ny = ny + SPD;
            2'b10:   if (nx < SPD) ok = 1'b0; else nx = nx - SPD;
            2'b11:   nx = nx + SPD;
            default: ok = 1'b0;
        endcase
        if ((nx > X_MAX) || (ny > Y_MAX)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return {ok, nx[9:0], ny[9:0]};
    endfunction

    // Axis-aligned box overlap between a bullet and a tank, compared in 11 bits
    function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                     input logic [9:0] tx, input logic [9:0] ty);
        logic [10:0] ebx;
        logic [10:0] eby;
        logic [10:0] etx;
        logic [10:0] ety;
        ebx = {1'b0, bx};
        eby = {1'b0, by};
        etx = {1'b0, tx};
        ety = {1'b0, ty};
        return (ebx < etx + T_SZ) && (ebx + B_SZ > etx) &&
               (eby < ety + T_SZ) && (eby + B_SZ > ety);
    endfunction

    // Population count of a slot vector
    function automatic logic [NW-1:0] popcount(input logic [MAX_BULLETS-1:0] v);
        logic [NW-1:0] c;
        c = {NW{1'b0}};
        for (int i = 0; i < MAX_BULLETS; i++) begin
            c = c + NW'(v[i]);
        end
        return c;
    endfunction

    logic [MAX_BULLETS-1:0] r_active;
    logic [9:0]             r_bx [MAX_BULLETS];
    logic [9:0]             r_by [MAX_BULLETS];
    logic [1:0]             r_dir [MAX_BULLETS];
    logic [CW-1:0]          r_cool;
    logic [DW-1:0]          r_div;
    logic [NUM_TARGETS-1:0] r_hit;
    logic                   r_accept;
    logic                   r_drop;
    logic [NW-1:0]          r_count;

    logic [MAX_BULLETS-1:0] w_active_nxt;
    logic [9:0]             w_bx_nxt [MAX_BULLETS];
    logic [9:0]             w_by_nxt [MAX_BULLETS];
    logic [1:0]             w_dir_nxt [MAX_BULLETS];
    logic [20:0]            w_step [MAX_BULLETS];
    logic [SW-1:0]          w_slot;
    logic                   w_any_free;
    logic                   w_accept;
    logic                   w_tick;
    logic [MAX_BULLETS-1:0] w_bhit;
    logic [NUM_TARGETS-1:0] w_hit_vec;

    assign w_tick   = (r_div == DW'(MOVE_DIV - 1));
    assign w_accept = fire & (r_cool == {CW{1'b0}}) & w_any_free;

    // Lowest-index free slot; uses registered occupancy so a slot freed this edge waits a cycle
    always_comb begin
        w_slot     = {SW{1'b0}};
        w_any_free = 1'b0;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_slot     = SW'(i);
                w_any_free = 1'b1;
            end else begin
                w_any_free = w_any_free;
            end
        end
    end

    // Hit detection; each bullet credits only the first target it overlaps
    always_comb begin
        w_bhit    = {MAX_BULLETS{1'b0}};
        w_hit_vec = {NUM_TARGETS{1'b0}};
        for (int b = 0; b < MAX_BULLETS; b++) begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (r_active[b] && target_alive[t] && !w_bhit[b] &&
                    overlap(r_bx[b], r_by[b], target_x[10*t +: 10], target_y[10*t +: 10])) begin
                    w_bhit[b]    = 1'b1;
                    w_hit_vec[t] = 1'b1;
                end else begin
                    w_bhit[b] = w_bhit[b];
                end
            end
        end
    end

    // Candidate moved position for every slot
    always_comb begin
        for (int b = 0; b < MAX_BULLETS; b++) begin
            w_step[b] = move_step(r_bx[b], r_by[b], r_dir[b]);
        end
    end

    // Slot next state: a hit beats movement, and a newly allocated slot does not move
    always_comb begin
        w_active_nxt = r_active;
        w_bx_nxt     = r_bx;
        w_by_nxt     = r_by;
        w_dir_nxt    = r_dir;
        for (int b = 0; b < MAX_BULLETS; b++) begin
            if (r_active[b]) begin
                if (w_bhit[b]) begin
                    w_active_nxt[b] = 1'b0;
                end else if (w_tick) begin
                    if (w_step[b][20]) begin
                        w_bx_nxt[b] = w_step[b][19:10];
                        w_by_nxt[b] = w_step[b][9:0];
                    end else begin
                        w_active_nxt[b] = 1'b0;
                    end
                end else begin
                    w_active_nxt[b] = 1'b1;
                end
            end else if (w_accept && (w_slot == SW'(b))) begin
                w_active_nxt[b] = 1'b1;
                w_bx_nxt[b]     = init_x;
                w_by_nxt[b]     = init_y;
                w_dir_nxt[b]    = fire_dir;
            end else begin
                w_active_nxt[b] = 1'b0;
            end
        end
    end

    // State registers, pulses, cooldown and movement divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= {MAX_BULLETS{1'b0}};
            for (int i = 0; i < MAX_BULLETS; i++) begin
                r_bx[i]  <= 10'd0;
                r_by[i]  <= 10'd0;
                r_dir[i] <= 2'd0;
            end
            r_cool   <= {CW{1'b0}};
            r_div    <= {DW{1'b0}};
            r_hit    <= {NUM_TARGETS{1'b0}};
            r_accept <= 1'b0;
            r_drop   <= 1'b0;
            r_count  <= {NW{1'b0}};
        end else begin
            r_active <= w_active_nxt;
            r_bx     <= w_bx_nxt;
            r_by     <= w_by_nxt;
            r_dir    <= w_dir_nxt;
            if (w_accept) begin
                r_cool <= CW'(COOLDOWN);
            end else if (r_cool != {CW{1'b0}}) begin
                r_cool <= r_cool - CW'(1);
            end else begin
                r_cool <= r_cool;
            end
            if (w_tick) begin
                r_div <= {DW{1'b0}};
            end else begin
                r_div <= r_div + DW'(1);
            end
            r_hit    <= w_hit_vec;
            r_accept <= w_accept;
            r_drop   <= fire & ~w_accept;
            r_count  <= popcount(w_active_nxt);
        end
    end

    assign fire_accept  = r_accept;
    assign fire_drop    = r_drop;
    assign hit          = r_hit;
    assign active       = r_active;
    assign active_count = r_count;

    for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_flat
        assign bullet_x[10*g +: 10]  = r_bx[g];
        assign bullet_y[10*g +: 10]  = r_by[g];
        assign bullet_dir[2*g +: 2]  = r_dir[g];
    end

endmodule
